event_arbiter_8: RTL and testbench

EVENT_ARBITER_8 -- requirements
Module: event_arbiter_8

---
 rtl/event_arbiter_8.sv | 114 +++++++++++
 tb/tb_event_arbiter_8.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/event_arbiter_8.sv
// ============================================================================
// Module      : event_arbiter_8
// Description : Captures rising edges on 8 event lines into a pending vector
//               and grants them one at a time in round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_arbiter_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic       grant_ack,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic [7:0] pending,
  output logic       overflow
);

  localparam logic [2:0] c_LAST_RST = 3'd7;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_req_prev;
  logic [7:0] r_pending;
  logic       r_overflow;
  logic [2:0] r_last;
  logic [2:0] r_grant_idx;
  logic [7:0] r_grant;
  logic       r_grant_valid;

  logic [7:0] w_rise;
  logic [7:0] w_clear;
  logic [7:0] w_pend_next;
  logic       w_lost;
  logic [2:0] w_sel_idx;
  logic [7:0] w_sel_onehot;

  // Scan last+8 down to last+1 so the nearest index after last is written last
  // and therefore wins; last itself only wins when it is the sole pending bit.
  function automatic logic [2:0] rr_pick(input logic [7:0] p, input logic [2:0] last);
    logic [2:0] k;
    logic [2:0] pick;
    pick = last;
    for (int i = 8; i >= 1; i--) begin
      k = last + 3'(i);
      if (p[k]) pick = k;
    end
    return pick;
  endfunction

  assign w_rise       = req_in & ~r_req_prev;
  assign w_clear      = (r_grant_valid && grant_ack) ? r_grant : 8'h00;
  assign w_pend_next  = (r_pending & ~w_clear) | w_rise;
  assign w_lost       = |(w_rise & r_pending & ~w_clear);
  assign w_sel_idx    = rr_pick(r_pending, r_last);
  assign w_sel_onehot = 8'h01 << w_sel_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_req_prev    <= 8'h00;
      r_pending     <= 8'h00;
      r_overflow    <= 1'b0;
      r_last        <= c_LAST_RST;
      r_grant_idx   <= 3'd0;
      r_grant       <= 8'h00;
      r_grant_valid <= 1'b0;
    end else begin
      r_req_prev <= req_in;
      r_pending  <= w_pend_next;
      if (w_lost) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_grant       <= w_sel_onehot;
            r_grant_idx   <= w_sel_idx;
            r_grant_valid <= 1'b1;
            r_state       <= GRANT;
          end else begin
            r_grant       <= 8'h00;
            r_grant_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (grant_ack) begin
            r_last        <= r_grant_idx;
            r_grant       <= 8'h00;
            r_grant_valid <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_grant       <= 8'h00;
          r_grant_valid <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign pending     = r_pending;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_event_arbiter_8.sv
// ============================================================================
// Module      : tb_event_arbiter_8
// Description : Directed and random checks of event_arbiter_8 against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_event_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic       grant_ack;
  logic [7:0] grant;
  logic       grant_valid;
  logic [7:0] pending;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  // Reference state: granted line number (-1 = none), pending lines, history.
  bit [7:0] m_prev;
  bit [7:0] m_pend;
  bit       m_ovf;
  int       m_last;
  int       m_g;

  always #5 clk = ~clk;

  event_arbiter_8 dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .grant_ack  (grant_ack),
    .grant      (grant),
    .grant_valid(grant_valid),
    .pending    (pending),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rs, input bit [7:0] r, input bit a);
    bit [7:0] newpend;
    bit       clr;
    bit       rise;
    bit       found;
    int       idx;
    if (rs) begin
      m_prev = 0; m_pend = 0; m_ovf = 0; m_last = 7; m_g = -1;
      return;
    end
    newpend = 0;
    for (int b = 0; b < 8; b++) begin
      clr  = (m_g == b) && a;
      rise = r[b] && !m_prev[b];
      if (rise && m_pend[b] && !clr) m_ovf = 1;
      newpend[b] = (m_pend[b] && !clr) || rise;
    end
    if (m_g >= 0) begin
      if (a) begin
        m_last = m_g;
        m_g    = -1;
      end
    end else begin
      found = 0;
      for (int d = 1; d <= 8; d++) begin
        idx = (m_last + d) % 8;
        if (!found && m_pend[idx]) begin
          m_g   = idx;
          found = 1;
        end
      end
    end
    m_prev = r;
    m_pend = newpend;
  endtask

  task automatic cycle(input logic rs, input logic [7:0] r, input logic a);
    logic [7:0] eg;
    rst = rs; req_in = r; grant_ack = a;
    @(posedge clk);
    model_step(rs, r, a);
    #1;
    eg = (m_g >= 0) ? (8'h01 << m_g) : 8'h00;
    chk("grant",    grant,                 eg);
    chk("valid",    {7'b0, grant_valid},   {7'b0, (m_g >= 0)});
    chk("pending",  pending,               m_pend);
    chk("overflow", {7'b0, overflow},      {7'b0, m_ovf});
    chk("onehot",   {7'b0, ($countones(grant) <= 1)}, 8'h01);
  endtask

  initial begin
    rst = 1'b1; req_in = 8'h00; grant_ack = 1'b0;
    m_prev = 0; m_pend = 0; m_ovf = 0; m_last = 7; m_g = -1;

    // Reset state
    cycle(1, 8'h00, 0);
    cycle(1, 8'h00, 0);
    chk("rst_grant", grant, 8'h00);
    chk("rst_pend",  pending, 8'h00);
    chk("rst_ovf",   {7'b0, overflow}, 8'h00);

    // Single event on line 3, grant latency and ack
    cycle(0, 8'h08, 0);
    chk("r26_pend", pending, 8'h08);
    chk("r26_v0",   {7'b0, grant_valid}, 8'h00);
    cycle(0, 8'h08, 0);
    chk("r26_grant", grant, 8'h08);
    chk("r26_v1",    {7'b0, grant_valid}, 8'h01);
    cycle(0, 8'h08, 1);
    chk("r26_pend0", pending, 8'h00);
    chk("r26_vack",  {7'b0, grant_valid}, 8'h00);
    cycle(0, 8'h00, 0);

    // Simultaneous rise on lines 1 and 5
    cycle(1, 8'h00, 0);
    cycle(0, 8'h22, 0);
    cycle(0, 8'h22, 0);
    chk("r27_first", grant, 8'h02);
    cycle(0, 8'h22, 1);
    chk("r27_gap", grant, 8'h00);
    cycle(0, 8'h22, 0);
    chk("r27_second", grant, 8'h20);
    cycle(0, 8'h00, 1);

    // last=5, pending 0x44 -> line 6 before line 2
    cycle(1, 8'h00, 0);
    cycle(0, 8'h20, 0);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h44, 0);
    chk("r28_pend", pending, 8'h44);
    cycle(0, 8'h00, 0);
    chk("r28_first", grant, 8'h40);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
    chk("r28_second", grant, 8'h04);
    cycle(0, 8'h00, 1);

    // Line 4 pulses twice before ack -> sticky overflow, single grant
    cycle(1, 8'h00, 0);
    cycle(0, 8'h10, 0);
    cycle(0, 8'h00, 0);
    chk("r29_grant", grant, 8'h10);
    cycle(0, 8'h10, 0);
    chk("r29_ovf", {7'b0, overflow}, 8'h01);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 0);
    chk("r29_nogrant", {7'b0, grant_valid}, 8'h00);
    chk("r29_sticky",  {7'b0, overflow}, 8'h01);

    // Line 3 rises in its own ack cycle -> re-pended, no overflow
    cycle(1, 8'h00, 0);
    cycle(0, 8'h08, 0);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h08, 1);
    chk("r30_pend", pending, 8'h08);
    chk("r30_ovf",  {7'b0, overflow}, 8'h00);
    cycle(0, 8'h00, 0);
    chk("r30_regrant", grant, 8'h08);
    cycle(0, 8'h00, 1);

    // Reset mid-grant with simultaneous ack
    cycle(1, 8'h00, 0);
    cycle(0, 8'h02, 0);
    cycle(0, 8'h00, 0);
    chk("r31_pre", grant, 8'h02);
    cycle(1, 8'h00, 1);
    chk("r31_grant", grant, 8'h00);
    chk("r31_valid", {7'b0, grant_valid}, 8'h00);
    cycle(0, 8'h81, 0);
    cycle(0, 8'h00, 0);
    chk("r31_line0", grant, 8'h01);
    cycle(0, 8'h00, 1);

    // Line held high across reset deassertion counts as one event
    cycle(1, 8'h04, 0);
    cycle(0, 8'h04, 0);
    chk("hold_rst", pending, 8'h04);
    cycle(0, 8'h04, 0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      cycle(($urandom_range(0, 99) == 0), r, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
